// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a registered one-hot grant, release on
// done / dropped request / hold limit, and a one-cycle timeout pulse.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [7:0]         r_grant, w_grant_nxt;
    logic [2:0]         r_idx, w_idx_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_timeout, w_timeout_nxt;

    logic [15:0]        w_dbl;
    logic [7:0]         w_rot;
    logic [2:0]         w_off;
    logic [2:0]         w_sel;
    logic               w_found;
    logic               w_rel_done, w_rel_drop, w_rel_lim;

    // Rotate req so the pointer position lands at bit 0; the lowest set bit
    // of the rotated vector is then the round-robin winner.
    always_comb begin
        w_dbl   = {req, req};
        w_rot   = 8'(w_dbl >> r_ptr);
        w_off   = 3'd0;
        w_found = |req;
        for (int i = 7; i >= 0; i--) begin
            if (w_rot[i]) w_off = 3'(i);
        end
        w_sel = r_ptr + w_off;
    end

    assign w_rel_done = done;
    assign w_rel_drop = ~req[r_idx];
    assign w_rel_lim  = (r_cnt == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_grant_nxt   = r_grant;
        w_idx_nxt     = r_idx;
        w_valid_nxt   = r_valid;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = 8'b1 << w_sel;
                    w_idx_nxt   = w_sel;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_rel_done || w_rel_drop || w_rel_lim) begin
                    w_grant_nxt   = 8'h00;
                    w_valid_nxt   = 1'b0;
                    w_ptr_nxt     = r_idx + 3'd1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = w_rel_lim && !w_rel_done && !w_rel_drop;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= 3'd0;
            r_cnt     <= '0;
            r_grant   <= 8'h00;
            r_idx     <= 3'd0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_grant   <= w_grant_nxt;
            r_idx     <= w_idx_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_idx;
    assign grant_valid = r_valid;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8 (MAX_HOLD=4): vector table, directed corner
// sequences, then random traffic against a grant-counting reference model.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant), .grant_idx(grant_idx),
        .grant_valid(grant_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] req;
        logic       done;
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic       to;
    } vec_t;

    vec_t tbl[18];

    // Reference model: owner is -1 when idle, held counts grant cycles so far.
    int m_owner, m_last, m_ptr, m_held;
    bit m_to;

    function automatic void model_reset();
        m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_to = 0;
    endfunction

    function automatic void model_step(input logic [7:0] r, input logic d);
        bit rel_drop, rel_lim;
        m_to = 0;
        if (m_owner < 0) begin
            for (int k = 0; k < 8; k++) begin
                int j;
                j = (m_ptr + k) % 8;
                if (r[j]) begin
                    m_owner = j; m_last = j; m_held = 1;
                    break;
                end
            end
        end else begin
            rel_drop = !r[m_owner];
            rel_lim  = (m_held == MAX_HOLD);
            if (d || rel_drop || rel_lim) begin
                m_to    = rel_lim && !d && !rel_drop;
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [12:0] got, input logic [12:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got grant=%h idx=%0d valid=%b to=%b, want grant=%h idx=%0d valid=%b to=%b",
                     name, got[12:5], got[4:2], got[1], got[0], exp[12:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [12:0] outs();
        return {grant, grant_idx, grant_valid, timeout};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00; done = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0};
        tbl[1]  = '{8'h00, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0};
        tbl[2]  = '{8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
        tbl[3]  = '{8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
        tbl[4]  = '{8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
        tbl[5]  = '{8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
        tbl[6]  = '{8'h02, 1'b0, 8'h00, 3'd1, 1'b0, 1'b1};
        tbl[7]  = '{8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
        tbl[8]  = '{8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
        tbl[9]  = '{8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
        tbl[10] = '{8'h02, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0};
        tbl[11] = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
        tbl[12] = '{8'h81, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0};
        tbl[13] = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[14] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[15] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[16] = '{8'hFF, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0};
        tbl[17] = '{8'hFF, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0};

        // Reset state, sampled while rst is still high
        #7;
        chk("reset_state", outs(), 13'h0);
        do_reset();

        foreach (tbl[i]) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            step();
            chk($sformatf("vec%0d", i), outs(), {tbl[i].g, tbl[i].idx, tbl[i].v, tbl[i].to});
        end

        // Fairness: all requesting, done in each grant's 2nd cycle
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            logic [2:0] e;
            e = 3'(k % 8);
            done = 1'b0;
            step();
            chk($sformatf("rr%0d_c1", k), outs(), {8'b1 << e, e, 1'b1, 1'b0});
            step();
            chk($sformatf("rr%0d_c2", k), outs(), {8'b1 << e, e, 1'b1, 1'b0});
            done = 1'b1;
            step();
            chk($sformatf("rr%0d_rel", k), outs(), {8'h00, e, 1'b0, 1'b0});
        end
        done = 1'b0;

        // Asynchronous reset in the middle of a grant cycle
        do_reset();
        req = 8'h20;
        step();
        chk("pre_rst_grant", outs(), {8'h20, 3'd5, 1'b1, 1'b0});
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst", outs(), 13'h0);
        req = 8'h24;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_ptr0", outs(), {8'h04, 3'd2, 1'b1, 1'b0});

        // Random traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [12:0] exp;
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(3))
                    0: req = 8'h00;
                    1: req = 8'(1 << $urandom_range(7));
                    2: req = 8'($urandom) & 8'($urandom);
                    default: req = 8'($urandom);
                endcase
            end
            done = ($urandom_range(7) == 0);
            step();
            model_step(req, done);
            exp = {(m_owner >= 0) ? (8'b1 << m_owner) : 8'h00, 3'(m_last),
                   (m_owner >= 0), m_to};
            chk($sformatf("rand%0d", c), outs(), exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter sharing one resource among eight requesters. It selects one requester, drives a registered one-hot grant (3-to-8 decode of the granted index) and holds the grant until the requester releases it, signals done, or exceeds a hold limit. It sits in front of any shared datapath whose select lines are one-hot, such as a bus or memory port.

## Interface
- MAX_HOLD, 16: maximum consecutive GRANT cycles per grant; legal range 2..256.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD.

- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous and active-high.
- req  input  8  request vector, one bit per requester, level-sensitive.
- done  input  1  release pulse from the current owner; ignored outside GRANT.
- grant  output  8  registered one-hot grant; all zeros when no owner.
- grant_idx  output  3  binary index of the current or last owner.
- grant_valid  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

## Operation
- States: IDLE and GRANT. Internal state: 3-bit priority pointer ptr and hold counter cnt.
- Reset (async, immediate) sets the following:
  - state=IDLE, ptr=0, cnt=0
  - grant=8'h00, grant_idx=0, grant_valid=0, timeout=0
- IDLE, req==0: remain in IDLE; outputs stay zero except grant_idx, which holds its last value.
- IDLE, req!=0: choose the first set bit of req searching ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8). On the same edge:
  - grant_idx=sel and grant=1<<sel
  - grant_valid=1, cnt=0, state=GRANT
- GRANT: release conditions are checked in this priority order, with any one sufficient:
  - (a) done==1.
  - (b) req[grant_idx]==0.
  - (c) cnt==MAX_HOLD-1.
- On release:
  - grant=0 and grant_valid=0.
  - ptr=grant_idx+1 mod 8, so 7 wraps to 0.
  - state=IDLE.
  - timeout=1 only if (c) is the sole cause. If (a) or (b) also holds, timeout=0.
- If GRANT does not release: cnt increments and grant is unchanged. Changes on other req bits have no effect during GRANT.
- timeout is high for exactly one cycle, the first IDLE cycle after a forced release.
- grant is always one-hot or zero; never multi-hot.

## Timing
- Arbitration latency: req seen at edge N in IDLE gives grant valid after edge N. The registered grant is visible in cycle N+1.
- Grant duration, starting with the first grant cycle as cycle 1:
  - Maximum is MAX_HOLD cycles.
  - With done asserted in grant cycle k, grant drops after the edge ending cycle k, so the grant lasts k cycles.
- Mandatory one IDLE cycle between consecutive grants; a back-to-back owner change takes 1 dead cycle.
- Fairness: with all req held high, each requester receives one grant every 8 grant periods.
- Reset mid-GRANT: outputs go to reset values asynchronously, without waiting for a clock edge. After reset, arbitration restarts from ptr=0.
- done in IDLE: no effect. done in the same cycle as the timeout limit: a normal release, timeout=0.

## Test plan
- Reset, then req=8'h10 held: one cycle later grant=8'h10, grant_idx=4, grant_valid=1. Drop req[4], and one cycle later grant=8'h00.
- req=8'hFF held, done pulsed on each grant's 2nd cycle: the grant_idx sequence is 0,1,2,…,7,0. Each grant lasts 2 cycles with 1 dead cycle between grants.
- Wrap: finish a grant on idx 6, then req=8'h81. The next grant goes to 7; after that release, the next goes to 0.
- MAX_HOLD=4, req=8'h02 held, done=0:
  - grant=8'h02 for exactly 4 cycles.
  - timeout pulses for 1 cycle.
  - req[1] is still high, so grant=8'h02 again after the dead cycle.
- Same setup, with done asserted in the 4th grant cycle: release occurs and timeout stays 0.
- rst asserted mid-clock during grant=8'h20: grant=0, grant_valid=0 and timeout=0 immediately. After rst drops with req=8'h24, the grant goes to idx 2 because ptr was reset to 0.
